// File: rtl/bpsk_tx_pkg.sv
// Shared types, constants and the sine table generator for the BPSK transmitter.
package bpsk_tx_pkg;

    localparam int unsigned SAMPLE_W = 14;
    localparam logic [SAMPLE_W-1:0] DAC_OFFSET = 14'h2000;
    localparam int LUT_AMP = 8191;
    localparam int unsigned PIPE_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DRAIN
    } tx_state_e;

    // Modulation sign carried down the sample pipeline
    typedef enum logic [1:0] {
        SGN_ZERO,
        SGN_POS,
        SGN_NEG
    } sign_e;

    // round(LUT_AMP * sin(2*pi*k/n)), rounded half away from zero
    function automatic logic signed [SAMPLE_W-1:0] sine_entry(input int k, input int n);
        real v;
        int  r;
        v = real'(LUT_AMP) * $sin(2.0 * 3.141592653589793 * real'(k) / real'(n));
        if (v >= 0.0) r = $rtoi(v + 0.5);
        else          r = -$rtoi(0.5 - v);
        return $signed(SAMPLE_W'(r));
    endfunction

endpackage

// File: rtl/bpsk_tx_modulator_nco.sv
// Phase accumulator feeding a registered address stage and a registered sine ROM.
module nco_sine_lut
    import bpsk_tx_pkg::*;
#(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned LUT_AW  = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic [PHASE_W-1:0]         fcw_i,
    output logic signed [SAMPLE_W-1:0] sample_o
);

    localparam int unsigned LUT_N = 2 ** LUT_AW;

    logic [PHASE_W-1:0]         phase_q;
    logic [LUT_AW-1:0]          addr_q;
    logic signed [SAMPLE_W-1:0] lut_q;
    logic signed [SAMPLE_W-1:0] rom [LUT_N];

    // Full-wave sine table, constant after elaboration
    for (genvar k = 0; k < int'(LUT_N); k++) begin : g_rom
        assign rom[k] = sine_entry(k, int'(LUT_N));
    end

    // Accumulate phase (held at zero while cleared), then address, then ROM data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
            addr_q  <= '0;
            lut_q   <= '0;
        end else begin
            phase_q <= clr_i ? '0 : phase_q + fcw_i;
            addr_q  <= phase_q[PHASE_W-1 -: LUT_AW];
            lut_q   <= rom[addr_q];
        end
    end

    assign sample_o = lut_q;

endmodule

// File: rtl/bpsk_tx_modulator.sv
// BPSK transmitter: preamble + (optionally differential) data symbols on an NCO carrier.
module bpsk_tx_modulator
    import bpsk_tx_pkg::*;
#(
    parameter int unsigned PHASE_W      = 32,
    parameter int unsigned LUT_AW       = 10,
    parameter int unsigned SAMP_PER_SYM = 100,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       tx_en,
    input  logic [PHASE_W-1:0]         fcw_in,
    input  logic                       diff_en,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       bit_ready,
    output logic signed [SAMPLE_W-1:0] sigout,
    output logic [SAMPLE_W-1:0]        dac_dataA_out,
    output logic [SAMPLE_W-1:0]        dac_dataB_out,
    output logic                       sym_strobe,
    output logic                       busy,
    output logic                       underrun
);

    localparam int unsigned SYM_CNT_W = $clog2(SAMP_PER_SYM);
    localparam int unsigned PRE_CNT_W = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
    localparam int unsigned DRAIN_W   = $clog2(PIPE_LAT);

    localparam logic [SYM_CNT_W-1:0] SYM_LAST   = SYM_CNT_W'(SAMP_PER_SYM - 1);
    localparam logic [SYM_CNT_W-1:0] SYM_PENULT = SYM_CNT_W'(SAMP_PER_SYM - 2);
    localparam logic [PRE_CNT_W-1:0] PRE_LAST   = PRE_CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

    tx_state_e            state_q;
    logic [SYM_CNT_W-1:0] sym_cnt_q;
    logic [PRE_CNT_W-1:0] pre_cnt_q;
    logic [DRAIN_W-1:0]   drain_cnt_q;
    logic [PHASE_W-1:0]   fcw_q;
    logic                 diff_q;
    logic                 sym_q;
    logic                 ready_q;
    logic                 underrun_q;
    logic                 busy_q;

    sign_e                      sgn_p1_q, sgn_p2_q;
    logic                       stb_p1_q, stb_p2_q;
    logic signed [SAMPLE_W-1:0] sig_q;
    logic [SAMPLE_W-1:0]        dac_a_q, dac_b_q;
    logic                       strobe_q;

    logic                       accept_pos_c;
    logic                       at_bnd_c;
    logic                       ready_d;
    logic                       fire_c;
    logic                       sym_enc_d;
    logic                       nco_clr_c;
    sign_e                      sgn_c;
    logic                       stb_c;
    logic signed [SAMPLE_W-1:0] lut_c;
    logic signed [SAMPLE_W-1:0] sig_d;

    nco_sine_lut #(
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW)
    ) u_nco (
        .clk_i    (clk_in),
        .rst_i    (rst_in),
        .clr_i    (nco_clr_c),
        .fcw_i    (fcw_q),
        .sample_o (lut_c)
    );

    // Symbol-boundary decode, handshake and encoder next value
    always_comb begin
        accept_pos_c = (state_q == ST_DATA) ||
                       ((state_q == ST_PREAMBLE) && (pre_cnt_q == PRE_LAST));
        at_bnd_c     = (sym_cnt_q == SYM_LAST);
        ready_d      = tx_en && accept_pos_c && (sym_cnt_q == SYM_PENULT);
        fire_c       = bit_valid && ready_q;
        sym_enc_d    = diff_q ? (sym_q ^ ~bit_in) : bit_in;
        nco_clr_c    = (state_q == ST_IDLE) ||
                       ((state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LAST));
    end

    // Sign and strobe for the sample whose phase is currently in the accumulator
    always_comb begin
        sgn_c = SGN_ZERO;
        stb_c = 1'b0;
        case (state_q)
            ST_PREAMBLE: begin
                sgn_c = SGN_POS;
                stb_c = (sym_cnt_q == '0);
            end
            ST_DATA: begin
                sgn_c = sym_q ? SGN_POS : SGN_NEG;
                stb_c = (sym_cnt_q == '0);
            end
            default: ;
        endcase
    end

    // Transmit FSM with symbol, preamble and drain counters
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            sym_cnt_q   <= '0;
            pre_cnt_q   <= '0;
            drain_cnt_q <= '0;
            fcw_q       <= '0;
            diff_q      <= 1'b0;
            sym_q       <= 1'b1;
            ready_q     <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            underrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    sym_cnt_q <= '0;
                    pre_cnt_q <= '0;
                    if (tx_en) begin
                        state_q <= ST_PREAMBLE;
                        fcw_q   <= fcw_in;
                        diff_q  <= diff_en;
                        sym_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PREAMBLE, ST_DATA: begin
                    if (!at_bnd_c) begin
                        sym_cnt_q <= sym_cnt_q + SYM_CNT_W'(1);
                    end else begin
                        sym_cnt_q <= '0;
                        if ((state_q == ST_PREAMBLE) && (pre_cnt_q != PRE_LAST)) begin
                            pre_cnt_q <= pre_cnt_q + PRE_CNT_W'(1);
                        end else if (fire_c) begin
                            state_q <= ST_DATA;
                            sym_q   <= sym_enc_d;
                        end else begin
                            // A missed offer is an underrun; a withheld offer is a clean stop
                            state_q     <= ST_DRAIN;
                            drain_cnt_q <= '0;
                            underrun_q  <= ready_q;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Apply the pipelined sign to the ROM sample
    always_comb begin
        sig_d = '0;
        case (sgn_p2_q)
            SGN_POS: sig_d = lut_c;
            SGN_NEG: sig_d = -lut_c;
            default: sig_d = '0;
        endcase
    end

    // Sign/strobe delay line matched to the NCO stages, then output formatting
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sgn_p1_q <= SGN_ZERO;
            sgn_p2_q <= SGN_ZERO;
            stb_p1_q <= 1'b0;
            stb_p2_q <= 1'b0;
            sig_q    <= '0;
            dac_a_q  <= DAC_OFFSET;
            dac_b_q  <= DAC_OFFSET;
            strobe_q <= 1'b0;
        end else begin
            sgn_p1_q <= sgn_c;
            sgn_p2_q <= sgn_p1_q;
            stb_p1_q <= stb_c;
            stb_p2_q <= stb_p1_q;
            sig_q    <= sig_d;
            dac_a_q  <= sig_d ^ DAC_OFFSET;
            dac_b_q  <= lut_c ^ DAC_OFFSET;
            strobe_q <= stb_p2_q;
        end
    end

    assign bit_ready     = ready_q;
    assign sigout        = sig_q;
    assign dac_dataA_out = dac_a_q;
    assign dac_dataB_out = dac_b_q;
    assign sym_strobe    = strobe_q;
    assign busy          = busy_q;
    assign underrun      = underrun_q;

endmodule

// File: doc/bpsk_tx_modulator.md
# bpsk_tx_modulator

BPSK transmitter that serves as the stimulus end of the Costas-loop demodulator path. It accepts a serial bit stream over a valid/ready handshake and emits an NCO-generated carrier, sign-modulated per symbol, as 14-bit signed samples. Each transmission begins with a fixed all-ones preamble so the receiver loop can lock. The outputs drive the DAC pair directly, or the demodulator's `sigin` in loopback.

## Interface
- `PHASE_W`, 32: NCO phase accumulator width.
- `LUT_AW`, 10: sine LUT address width; address = `phase[PHASE_W-1 -: LUT_AW]`.
- `SAMP_PER_SYM`, 100: clock cycles per symbol; must be ≥ 2.
- `PREAMBLE_LEN`, 32: preamble symbols per transmission; must be ≥ 1.

Ports:
- `clk_in` in 1: single clock, 100 MHz.
- `rst_in` in 1: reset, synchronous, active-high.
- `tx_en` in 1: level; high requests or continues transmission.
- `fcw_in` in PHASE_W: carrier frequency control word; latched on IDLE→PREAMBLE.
- `diff_en` in 1: differential encoding enable; latched on IDLE→PREAMBLE.
- `bit_in` in 1: data bit.
- `bit_valid` in 1: `bit_in` valid.
- `bit_ready` out 1: registered; a bit is consumed on a cycle where `bit_valid & bit_ready`.
- `sigout` out 14: signed modulated sample, two's complement.
- `dac_dataA_out` out 14: `sigout` in offset binary (`sigout ^ 14'h2000`).
- `dac_dataB_out` out 14: unmodulated carrier in offset binary, used as scope/reference.
- `sym_strobe` out 1: one-cycle pulse aligned with the first output sample of each symbol.
- `busy` out 1: high when not IDLE.
- `underrun` out 1: one-cycle pulse when DATA ends because no bit was available.

## Operation
- FSM states: IDLE, PREAMBLE, DATA, DRAIN.
- IDLE: phase = 0, symbol counter = 0, and the modulation sign is forced to zero-amplitude. If `tx_en`, go to PREAMBLE and latch `fcw_in` and `diff_en`.
- PREAMBLE: send `PREAMBLE_LEN` symbols with sign +1. The encoder state is initialised to 1.
- In PREAMBLE (last symbol) and in DATA, `bit_ready` is high in the cycle where `sym_cnt == SAMP_PER_SYM-1`, and only then.
  - Handshake taken: the next symbol is the encoded bit; state goes to DATA.
  - Handshake not taken: pulse `underrun` and go to DRAIN.
  - `tx_en` low at that boundary: `bit_ready` is held 0 and state goes to DRAIN; `underrun` is not pulsed.
- Encoding:
  - `diff_en = 0`: sym = `bit_in`.
  - `diff_en = 1`: sym = prev_sym XOR ~`bit_in`, so a 0 flips the phase.
  - Sign mapping: sym 1 → +carrier, sym 0 → −carrier.
- DRAIN: wait out the pipeline latency (3 cycles) with zero amplitude, then go to IDLE.
- NCO: `phase <= phase + fcw` every cycle outside IDLE. LUT entry k = round(8191·sin(2πk/2^LUT_AW)); the range ±8191 makes negation overflow-free.
- Sign is pipelined with the phase, so symbol boundaries are sample-exact.
- `dac_dataB_out` tracks the LUT output with no sign applied, and is midscale in IDLE.

## Timing
- Reset values:
  - `sigout` = 0.
  - `dac_dataA_out` = `dac_dataB_out` = 14'h2000.
  - `bit_ready`, `busy`, `sym_strobe`, `underrun` = 0.
  - FSM = IDLE, phase = 0.
- Reset mid-transmission: all of the above apply on the next edge, and the in-flight symbol is dropped.
- Latency: `tx_en` sampled high at edge t → `busy` high at t+1 → first preamble sample (phase 0) on `sigout` at t+4.
- Pipeline: phase register → LUT register → sign/output register.
- A bit accepted at edge t appears on `sigout` starting at t+4, coincident with `sym_strobe`.
- Simultaneous `tx_en` drop and `bit_valid` at the boundary: the bit is not consumed (ready = 0).
- Phase wraps modulo 2^PHASE_W, and the carrier stays continuous across symbols.

## Structure
- Package `bpsk_tx_pkg`: FSM state encoding, `SAMPLE_W = 14`, `DAC_OFFSET = 14'h2000`, `LUT_AMP = 8191`, `PIPE_LAT = 3`.
- Sub-module `nco_sine_lut`: phase accumulator plus registered full-wave sine ROM (initialised by generate/function), output 14-bit signed.
- The top holds the FSM, symbol counter, encoder, sign pipeline, and DAC formatting.

## Test plan
Tests use `LUT_AW=6`, `SAMP_PER_SYM=8`, `PREAMBLE_LEN=2`, `fcw_in = 32'h2000_0000`.
- Preamble: raise `tx_en` with `bit_valid` = 0. `sigout` repeats 0, 5792, 8191, 5792, 0, −5792, −8191, −5792 for 16 samples, then `underrun` pulses, then `sigout` = 0 and `busy` falls.
- Data: supply bits 1, 0, 1 with `diff_en=0`. The three data symbols after the preamble are +, −, + carrier, and `sym_strobe` pulses on each first sample.
- Differential: supply bits 1, 0, 0, 1 with `diff_en=1`. Symbol signs are +, −, +, +.
- Disable: drop `tx_en` mid-symbol. The current symbol completes all 8 samples, `bit_ready` stays 0 at the boundary, there is no `underrun` pulse, and the block reaches IDLE 3 cycles later.
- Reset: assert `rst_in` mid-DATA. On the next cycle `sigout` = 0, `dac_dataA_out` = 14'h2000, and all flags are 0.
- Loopback: drive `sigout` into the Costas demodulator with 256 random bits. The recovered bits match the input after lock, modulo the 180° ambiguity when `diff_en=0`.
